nios_system_onchip_arbiter: RTL
===============================

// Module: nios_system_onchip_arbiter
// PURPOSE
//  Shares one single-port on-chip RAM (16384 x 32, byte-enabled, 1-cycle read latency) among NUM_MASTERS
//  Nios cores of the parallel image-processing system. Round-robin issue of one access per cycle.
//  Optional per-master lock gives atomic read-modify-write, e.g. for shared tile counters and semaphores.
//  Sits between the per-core Avalon-MM data masters and the RAM's s1 slave.
// PARAMETERS
//  NUM_MASTERS   4    requesters; 2..8
//  ADDR_W        14   word address width (RAM depth 2**ADDR_W)
//  DATA_W        32   data width; BE_W = DATA_W/8
//  LOCK_TIMEOUT  64   idle cycles after which a held lock is force-released; 0 = never
// PORTS
//  clk              in   1              single clock, all logic on rising edge
//  reset            in   1              synchronous, active-high
//  m_address        in   N*ADDR_W       per-master word address, master i at [i*ADDR_W +: ADDR_W]
//  m_byteenable     in   N*BE_W         per-master byte enables
//  m_writedata      in   N*DATA_W       per-master write data
//  m_read           in   N              read request
//  m_write          in   N              write request
//  m_lock           in   N              hold grant after this access
//  m_waitrequest    out  N              1 = access not taken this cycle
//  m_readdata       out  DATA_W         shared return bus, qualified by m_readdatavalid
//  m_readdatavalid  out  N              one-hot pulse, read data for master i
//  ram_address      out  ADDR_W         to RAM address
//  ram_byteenable   out  BE_W           to RAM byteenable
//  ram_writedata    out  DATA_W         to RAM writedata
//  ram_chipselect   out  1              to RAM chipselect
//  ram_write        out  1              to RAM write
//  ram_clken        out  1              to RAM clken; = ~reset
//  ram_readdata     in   DATA_W         RAM q; valid the cycle after the read is issued
// BEHAVIOUR
//  - req[i] = m_read[i] | m_write[i]. If both are asserted, the access is a write. The bench asserts on this case.
//  - Grant is combinational, at most one per cycle:
//    - IDLE: first requesting i searching upward from rr_ptr, with wrap.
//    - LOCKED: lock_owner only; all other masters stall.
//  - Granted master: m_waitrequest[g]=0. RAM outputs are muxed from master g, with ram_chipselect=1 and
//    ram_write=m_write[g].
//  - All other masters have waitrequest=1. When there is no grant, chipselect=0 and write=0.
//  - rr_ptr <= (g+1) mod N on every IDLE grant. rr_ptr is frozen while LOCKED.
//  - Read return path:
//    - rd_pend and rd_idx are registered on an issued read.
//    - Next cycle: m_readdatavalid[rd_idx]=rd_pend and m_readdata=ram_readdata (combinational).
//    - Back-to-back reads sustain 1 per cycle; data returns in issue order.
//  - Lock FSM (2 states, encoded in shared defs):
//    - IDLE -> LOCKED: on a grant with m_lock[g]=1. Set lock_owner=g and clear idle_cnt.
//    - LOCKED -> LOCKED: owner issues with m_lock=1. Clear idle_cnt.
//    - LOCKED -> IDLE: owner issues with m_lock=0. That access completes. Then rr_ptr <= owner+1.
//    - LOCKED -> IDLE: req[owner]=0 for LOCK_TIMEOUT consecutive cycles (idle_cnt saturates, width clog2+1).
//      Raise the 1-cycle internal pulse lock_expired for the bench.
//  - Reset values: rr_ptr=0, state=IDLE, lock_owner=0, idle_cnt=0, rd_pend=0.
//    Outputs during reset: m_waitrequest=all 1, m_readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0.
//  - Reset mid-read: the pending read is dropped; no readdatavalid in the cycle after reset.
//  - Reset mid-lock: the lock is lost; state=IDLE.
//  - Address/data pass-through is not registered. The critical path is the grant mux into the RAM address register.
// STRUCTURE
//  - Shared include nios_arb_defs.vh: state encodings ARB_IDLE/ARB_LOCKED, and CLOG2 macro for index widths.
//  - Sub-module nios_rr_arbiter (N, req, rr_ptr -> one-hot grant, binary index, any).
//    Purely combinational rotate-priority-encoder, reused by the DMA engine.
//  - Top level holds the lock FSM, idle counter, read-return pipeline register and the RAM-side mux.
// TESTING
//  - Fairness: N=4, all masters read continuously from reset.
//    -> Grants 0,1,2,3,0,... one per cycle.
//    -> m_readdatavalid one-hot, one cycle after each grant, data = RAM model contents.
//  - Byte write then read: M2 writes 0xA5A5A5A5 to addr 0x0010 with be=4'b0100, then reads 0x0010.
//    -> Readback = old word with byte2 = 0xA5 only.
//  - Atomic RMW: M1 reads 0x3FFF with lock=1 while M0,M2,M3 request.
//    -> M1 increments and writes 0x3FFF with lock=0. Others stall until the write completes.
//    -> Next grant goes to M2; final value = old+1.
//  - Lock timeout (LOCK_TIMEOUT=8): M3 locks then drops its request.
//    -> Exactly 8 cycles later state=IDLE and M0 is granted on cycle 9.
//  - Reset mid-flight: assert reset in the cycle after M0 issues a read.
//    -> No m_readdatavalid; during reset waitrequest=4'hF and chipselect=0.
//    -> First grant after reset goes to M0.
//  - Read+write conflict: M1 asserts read and write together with data 0x12345678.
//    -> A write is performed; no readdatavalid for M1.

Source files
------------

// File: rtl/nios_system_onchip_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// nios_system_onchip_arbiter_pkg
// Shared definitions for the on-chip RAM arbiter and its round-robin core:
//   arb_state_t : lock FSM state encoding (ARB_IDLE / ARB_LOCKED)
//   idx_width() : width of a binary master index for a given master count,
//                 never less than one bit so that a two-master build still
//                 has a usable index.
// -----------------------------------------------------------------------------
package nios_system_onchip_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nios_system_onchip_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nios_rr_arbiter
// Purely combinational rotate-priority encoder. The search starts at rr_ptr
// and walks upward with wrap-around; the first requester found wins.
// Ports:
//   req       in   N       request vector
//   rr_ptr    in   IDX_W   index with highest priority this cycle
//   grant     out  N       one-hot grant (all zero when nobody requests)
//   grant_idx out  IDX_W   binary index of the granted requester
//   any       out  1       at least one requester was granted
// -----------------------------------------------------------------------------
module nios_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int idx;

    // Walk the requesters in priority order; only the first hit is kept.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant_idx  = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios_system_onchip_arbiter.sv
// -----------------------------------------------------------------------------
// nios_system_onchip_arbiter
// Shares one single-port on-chip RAM (byte-enabled, 1-cycle read latency)
// among NUM_MASTERS Avalon-MM data masters. One access is issued per cycle in
// round-robin order; a master may hold the grant (lock) for atomic
// read-modify-write sequences. A held lock is dropped after LOCK_TIMEOUT
// consecutive cycles without a request from its owner (0 = never).
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   m_address/byteenable/writedata per-master request fields, master i in slice i
//   m_read, m_write, m_lock       per-master request qualifiers
//   m_waitrequest                 1 = access not taken this cycle
//   m_readdata, m_readdatavalid   shared return bus, one-hot valid per master
//   ram_*                         RAM s1 slave side; ram_clken = ~reset
// -----------------------------------------------------------------------------
module nios_system_onchip_arbiter
    import nios_system_onchip_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS  = 4,
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 64,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             ram_address,
    output logic [BE_W-1:0]               ram_byteenable,
    output logic [DATA_W-1:0]             ram_writedata,
    output logic                          ram_chipselect,
    output logic                          ram_write,
    output logic                          ram_clken,
    input  logic [DATA_W-1:0]             ram_readdata
);

    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

    arb_state_t             state, state_nxt;
    logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]       lock_owner, lock_owner_nxt;
    logic [CNT_W-1:0]       idle_cnt, idle_cnt_nxt;
    logic                   rd_pend;
    logic [IDX_W-1:0]       rd_idx;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] arb_onehot;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    logic [NUM_MASTERS-1:0] gnt_onehot;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic                   issue_read;
    logic                   lock_expired;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_MASTERS - 1) ? '0 : i + 1'b1;
    endfunction

    assign req = m_read | m_write;

    nios_rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (arb_onehot),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Final grant: round-robin winner when idle, only the owner while locked,
    // and nobody at all while reset is asserted.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = arb_idx;
        gnt_any    = 1'b0;
        if (!reset) begin
            if (state == ARB_IDLE) begin
                gnt_onehot = arb_onehot;
                gnt_idx    = arb_idx;
                gnt_any    = arb_any;
            end else begin
                gnt_idx = lock_owner;
                gnt_any = req[lock_owner];
                if (req[lock_owner]) begin
                    gnt_onehot[lock_owner] = 1'b1;
                end
            end
        end
    end

    assign m_waitrequest  = ~gnt_onehot;
    assign ram_address    = m_address[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign ram_byteenable = m_byteenable[int'(gnt_idx)*BE_W +: BE_W];
    assign ram_writedata  = m_writedata[int'(gnt_idx)*DATA_W +: DATA_W];
    assign ram_chipselect = gnt_any;
    assign ram_write      = gnt_any & m_write[gnt_idx];
    assign ram_clken      = ~reset;

    // A simultaneous read and write is treated as a write, so no data returns.
    assign issue_read = gnt_any & m_read[gnt_idx] & ~m_write[gnt_idx];

    // Read data from the RAM is routed straight back; the valid strobe comes
    // from the index registered when the read was issued.
    assign m_readdata = ram_readdata;

    always_comb begin
        m_readdatavalid = '0;
        if (rd_pend && !reset) begin
            m_readdatavalid[rd_idx] = 1'b1;
        end
    end

    // Last idle cycle of a held lock whose owner has stopped requesting.
    assign lock_expired = (LOCK_TIMEOUT != 0) && (state == ARB_LOCKED) &&
                          !req[lock_owner] && (idle_cnt == CNT_LAST);

    // Lock FSM and round-robin pointer update. The pointer only moves on an
    // idle grant or when the owner releases with its final access; a timed-out
    // lock leaves it where it was.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        lock_owner_nxt = lock_owner;
        idle_cnt_nxt   = idle_cnt;
        case (state)
            ARB_IDLE: begin
                if (gnt_any) begin
                    rr_ptr_nxt = next_idx(gnt_idx);
                    if (m_lock[gnt_idx]) begin
                        state_nxt      = ARB_LOCKED;
                        lock_owner_nxt = gnt_idx;
                        idle_cnt_nxt   = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                if (req[lock_owner]) begin
                    idle_cnt_nxt = '0;
                    if (!m_lock[lock_owner]) begin
                        state_nxt  = ARB_IDLE;
                        rr_ptr_nxt = next_idx(lock_owner);
                    end
                end else if (lock_expired) begin
                    state_nxt    = ARB_IDLE;
                    idle_cnt_nxt = '0;
                end else if (idle_cnt != {CNT_W{1'b1}}) begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State registers and the read-return pipeline stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            rr_ptr     <= '0;
            lock_owner <= '0;
            idle_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_idx     <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            lock_owner <= lock_owner_nxt;
            idle_cnt   <= idle_cnt_nxt;
            rd_pend    <= issue_read;
            rd_idx     <= gnt_idx;
        end
    end

endmodule
